// File: rtl/pll_fb_resync_sequencer.sv
// pll_fb_resync_sequencer
//   Brings a CCC PLL out of powerdown and hands its divided outputs to the fabric.
//   Sequence: PD (dividers off, PLL held down) -> PWRUP (PLL released, settle)
//   -> LOCKW (wait for lock, bounded by a timeout with retries) -> EN (outputs
//   enabled one at a time, STAGGER cycles apart) -> RUN. Lock loss re-runs the
//   sequence. Too many lock timeouts park the block in FAILED until RESTART.
//   All flops update on the falling edge of FREF.
// Ports:
//   FREF         reference clock (falling-edge active)
//   RESET_N      asynchronous active-low reset
//   PLL_LOCK     PLL lock, asynchronous, synchronised internally
//   RESTART      single-cycle request to re-run the sequence
//   POWERDOWN_N  PLL powerdown, active-low
//   OUTx_EN      per-output divider enables
//   BUSY         sequence in progress
//   DONE         sequence complete, outputs running
//   FAIL         lock retries exhausted (sticky until RESTART/reset)
//   RETRY_CNT    lock timeouts seen in the current sequence
module pll_fb_resync_sequencer #(
   parameter int unsigned NUM_OUTPUTS  = 4,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DIS_WAIT     = 200,
   parameter int unsigned PD_WAIT      = 200,
   parameter int unsigned LOCK_TIMEOUT = 4096,
   parameter int unsigned STAGGER      = 8,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic                   FREF,
   input  logic                   RESET_N,
   input  logic                   PLL_LOCK,
   input  logic                   RESTART,
   output logic                   POWERDOWN_N,
   output logic [NUM_OUTPUTS-1:0] OUTx_EN,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   FAIL,
   output logic [1:0]             RETRY_CNT
);

   localparam int unsigned IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

   localparam logic [CNT_W-1:0]       DIS_LAST  = CNT_W'(DIS_WAIT - 1);
   localparam logic [CNT_W-1:0]       PD_LAST   = CNT_W'(PD_WAIT - 1);
   localparam logic [CNT_W-1:0]       TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]       STG_LAST  = CNT_W'(STAGGER - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_OUTPUTS - 1);
   localparam logic [NUM_OUTPUTS-1:0] EN_FIRST  = NUM_OUTPUTS'(1);
   localparam logic [1:0]             RETRY_MAX = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {StPd, StPwrup, StLockw, StEn, StRun, StFailed} state_e;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic             lock_meta;
   logic             lock_s;
   logic             to_pd;

   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
   assign idx_nxt = idx + 1'b1;

   // Every path back into PD funnels through one flag so the PD entry
   // actions (outputs cleared, counter cleared) are written once.
   always_comb begin
      to_pd = RESTART;
      case (state)
         StPd, StPwrup, StFailed: ;
         StLockw: if (!lock_s && cnt == TO_LAST && RETRY_CNT < RETRY_MAX) to_pd = 1'b1;
         StEn, StRun: if (!lock_s) to_pd = 1'b1;
         default: to_pd = 1'b1;
      endcase
   end

   always_ff @(negedge FREF or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= StPd;
         cnt         <= '0;
         idx         <= '0;
         lock_meta   <= 1'b0;
         lock_s      <= 1'b0;
         POWERDOWN_N <= 1'b0;
         OUTx_EN     <= '0;
         BUSY        <= 1'b1;
         DONE        <= 1'b0;
         FAIL        <= 1'b0;
         RETRY_CNT   <= 2'd0;
      end else begin
         lock_meta <= PLL_LOCK;
         lock_s    <= lock_meta;
         cnt       <= cnt_inc;
         if (to_pd) begin
            state       <= StPd;
            cnt         <= '0;
            POWERDOWN_N <= 1'b0;
            OUTx_EN     <= '0;
            BUSY        <= 1'b1;
            DONE        <= 1'b0;
            FAIL        <= 1'b0;
            // Lock loss in RUN starts a fresh sequence; a glitch during EN does not.
            if (RESTART || state == StRun) RETRY_CNT <= 2'd0;
            else if (state == StLockw)     RETRY_CNT <= RETRY_CNT + 2'd1;
         end else begin
            case (state)
               StPd: begin
                  if (cnt == DIS_LAST) begin
                     state       <= StPwrup;
                     cnt         <= '0;
                     POWERDOWN_N <= 1'b1;
                  end
               end
               StPwrup: begin
                  if (cnt == PD_LAST) begin
                     state <= StLockw;
                     cnt   <= '0;
                  end
               end
               StLockw: begin
                  // Lock wins over a timeout on the same cycle.
                  if (lock_s) begin
                     state   <= StEn;
                     cnt     <= '0;
                     idx     <= '0;
                     OUTx_EN <= EN_FIRST;
                  end else if (cnt == TO_LAST) begin
                     state       <= StFailed;
                     cnt         <= '0;
                     FAIL        <= 1'b1;
                     BUSY        <= 1'b0;
                     POWERDOWN_N <= 1'b0;
                     OUTx_EN     <= '0;
                  end
               end
               StEn: begin
                  if (cnt == STG_LAST) begin
                     cnt <= '0;
                     if (idx == IDX_LAST) begin
                        state <= StRun;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                     end else begin
                        idx     <= idx_nxt;
                        OUTx_EN <= OUTx_EN | (EN_FIRST << idx_nxt);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_fb_resync_sequencer.sv
// Bench for pll_fb_resync_sequencer. The reference model tracks the sequence as
// timestamps (attempt start, EN start) and derives expected outputs from elapsed
// cycle counts. A 4-output instance is fully checked; 1- and 8-output instances
// share the stimulus and are checked at reset and at their enable milestones.
module tb_pll_fb_resync_sequencer;

   localparam int DIS = 200, PDW = 200, TO = 16, STG = 8, MAXR = 3, N = 4;

   logic FREF = 1'b1;
   logic RESET_N, PLL_LOCK, RESTART;

   logic       pdn, busy, done, fail;
   logic [3:0] en;
   logic [1:0] rc;
   logic       pdn1, en1, busy1, done1, fail1;
   logic [1:0] rc1;
   logic       pdn8, busy8, done8, fail8;
   logic [7:0] en8;
   logic [1:0] rc8;
   logic [9:0] dut_vec;

   int total = 0;
   int bad   = 0;

   always #5 FREF = ~FREF;

   pll_fb_resync_sequencer #(.NUM_OUTPUTS(4), .LOCK_TIMEOUT(TO)) dut (
      .FREF(FREF), .RESET_N(RESET_N), .PLL_LOCK(PLL_LOCK), .RESTART(RESTART),
      .POWERDOWN_N(pdn), .OUTx_EN(en), .BUSY(busy), .DONE(done), .FAIL(fail), .RETRY_CNT(rc)
   );
   pll_fb_resync_sequencer #(.NUM_OUTPUTS(1), .LOCK_TIMEOUT(TO)) dut1 (
      .FREF(FREF), .RESET_N(RESET_N), .PLL_LOCK(PLL_LOCK), .RESTART(RESTART),
      .POWERDOWN_N(pdn1), .OUTx_EN(en1), .BUSY(busy1), .DONE(done1), .FAIL(fail1),
      .RETRY_CNT(rc1)
   );
   pll_fb_resync_sequencer #(.NUM_OUTPUTS(8), .LOCK_TIMEOUT(TO)) dut8 (
      .FREF(FREF), .RESET_N(RESET_N), .PLL_LOCK(PLL_LOCK), .RESTART(RESTART),
      .POWERDOWN_N(pdn8), .OUTx_EN(en8), .BUSY(busy8), .DONE(done8), .FAIL(fail8),
      .RETRY_CNT(rc8)
   );

   assign dut_vec = {pdn, en, busy, done, fail, rc};

   // ---------------- reference model ----------------
   int m_now, m_ph, m_en, m_retry;
   bit m_run, m_failed, m_s1, m_s2;

   task automatic model_reset();
      m_now = 0; m_ph = 0; m_en = -1; m_retry = 0;
      m_run = 0; m_failed = 0; m_s1 = 0; m_s2 = 0;
   endtask

   task automatic model_step(input bit rs, input bit lk);
      bit ls = m_s2;
      int e;
      m_now++;
      if (rs) begin
         m_ph = m_now; m_en = -1; m_run = 0; m_failed = 0; m_retry = 0;
      end else if (m_failed) begin
      end else if (m_run) begin
         if (!ls) begin m_run = 0; m_ph = m_now; m_retry = 0; end
      end else if (m_en >= 0) begin
         if (!ls) begin m_en = -1; m_ph = m_now; end
         else if (m_now - m_en == N * STG) begin m_en = -1; m_run = 1; end
      end else begin
         e = m_now - 1 - m_ph;
         if (e >= DIS + PDW) begin
            if (ls) m_en = m_now;
            else if (e - (DIS + PDW) == TO - 1) begin
               if (m_retry < MAXR) begin m_retry++; m_ph = m_now; end
               else m_failed = 1;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = lk;
   endtask

   // {powerdown_n, en[3:0], busy, done, fail, retry[1:0]}
   function automatic logic [9:0] exp_vec();
      logic [1:0] r = 2'(m_retry);
      int bits;
      if (m_failed) return {1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, r};
      if (m_run)    return {1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, r};
      if (m_en >= 0) begin
         bits = (m_now - m_en) / STG + 1;
         return {1'b1, 4'((1 << bits) - 1), 1'b1, 1'b0, 1'b0, r};
      end
      return {1'((m_now - m_ph) >= DIS), 4'b0000, 1'b1, 1'b0, 1'b0, r};
   endfunction

   task automatic tick();
      @(negedge FREF);
      model_step(RESTART, PLL_LOCK);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET_N = 1'b0; PLL_LOCK = 1'b1; RESTART = 1'b0;
      model_reset();
      #12;
      total++;
      if (dut_vec !== exp_vec()) begin
         bad++; $display("FAIL reset_n4 got=%b want=%b", dut_vec, exp_vec());
      end
      total++;
      if ({pdn1, en1, busy1, done1, fail1, rc1} !== 7'b0010000) begin
         bad++; $display("FAIL reset_n1 got=%b want=0010000", {pdn1, en1, busy1, done1, fail1, rc1});
      end
      total++;
      if ({pdn8, en8, busy8, done8, fail8, rc8} !== {1'b0, 8'h00, 5'b10000}) begin
         bad++; $display("FAIL reset_n8 got=%b", {pdn8, en8, busy8, done8, fail8, rc8});
      end
      @(posedge FREF);
      RESET_N = 1'b1;
   endtask

   task automatic test_power_on();
      int         ms_cyc [12] = '{199, 200, 400, 401, 408, 409, 416, 417, 424, 425, 432, 433};
      logic [5:0] ms_vec [12] = '{6'b0_0000_0, 6'b1_0000_0, 6'b1_0000_0, 6'b1_0001_0,
                                  6'b1_0001_0, 6'b1_0011_0, 6'b1_0011_0, 6'b1_0111_0,
                                  6'b1_0111_0, 6'b1_1111_0, 6'b1_1111_0, 6'b1_1111_1};
      for (int c = 0; c < 470; c++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL power_on cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
         for (int k = 0; k < 12; k++) begin
            if (m_now == ms_cyc[k]) begin
               total++;
               if ({pdn, en, done} !== ms_vec[k]) begin
                  bad++;
                  $display("FAIL milestone cyc=%0d got=%b want=%b", m_now, {pdn, en, done}, ms_vec[k]);
               end
            end
         end
         if (m_now == 401 || m_now == 408 || m_now == 409) begin
            total++;
            if ({en1, done1} !== {1'b1, 1'(m_now == 409)}) begin
               bad++; $display("FAIL n1_seq cyc=%0d got=%b", m_now, {en1, done1});
            end
         end
         if (m_now == 456 || m_now == 457 || m_now == 464 || m_now == 465) begin
            total++;
            if ({en8, done8} !== {(m_now == 456) ? 8'h7f : 8'hff, 1'(m_now == 465)}) begin
               bad++; $display("FAIL n8_seq cyc=%0d got=%b", m_now, {en8, done8});
            end
         end
      end
   endtask

   task automatic test_timeout();
      int steps[$];
      logic [1:0] last;
      int g = 0;
      PLL_LOCK = 1'b0;
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      last = rc;
      while (!m_failed && g < 2000) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL timeout cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
         if (rc !== last) begin steps.push_back(int'(rc)); last = rc; end
      end
      total++;
      if (steps.size() != 3 || steps[0] != 1 || steps[1] != 2 || steps[2] != 3) begin
         bad++; $display("FAIL retry_steps got_count=%0d want=3 (1,2,3)", steps.size());
      end
      repeat ($urandom_range(1, 20)) tick();
      total++;
      if ({fail, pdn, en, busy, rc} !== {1'b1, 1'b0, 4'b0, 1'b0, 2'd3}) begin
         bad++; $display("FAIL failed_sticky got=%b", {fail, pdn, en, busy, rc});
      end
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      total++;
      if ({fail, rc} !== 3'b000) begin
         bad++; $display("FAIL restart_clear got=%b want=000", {fail, rc});
      end
   endtask

   task automatic test_lock_loss();
      int g = 0;
      PLL_LOCK = 1'b1;
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      while (!m_run && g < 600) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL lock_up cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      repeat ($urandom_range(0, 15)) tick();
      PLL_LOCK = 1'b0;
      g = 0;
      while (pdn === 1'b1 && g < 8) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL lock_loss cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      total++;
      if ({pdn, en, done, busy} !== 7'b0_0000_0_1) begin
         bad++; $display("FAIL loss_pd_edge got=%b want=0000001", {pdn, en, done, busy});
      end
      PLL_LOCK = 1'b1;
      g = 0;
      while (!m_run && g < 600) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL relock cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL done_again got=%b want=1", done); end
   endtask

   task automatic test_en_glitch();
      int g = 0;
      PLL_LOCK = 1'b0;
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      while (m_retry != 1 && g < 600) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL glitch_pre cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      repeat ($urandom_range(1, 150)) tick();
      PLL_LOCK = 1'b1;
      g = 0;
      while (en !== 4'b0011 && g < 600) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL glitch_en cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      repeat ($urandom_range(0, 4)) tick();
      PLL_LOCK = 1'b0; tick(); PLL_LOCK = 1'b1;
      g = 0;
      while (pdn === 1'b1 && g < 6) begin
         tick(); g++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL glitch cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      total++;
      if ({en, rc, pdn} !== {4'b0000, 2'd1, 1'b0}) begin
         bad++; $display("FAIL glitch_result got=%b want=0000010", {en, rc, pdn});
      end
   endtask

   task automatic test_restart_timeout();
      int g = 0;
      int t;
      PLL_LOCK = 1'b0;
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      while (m_retry != 1 && g < 600) begin tick(); g++; end
      t = m_ph + DIS + PDW + TO;
      while (m_now < t - 1) begin
         tick();
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL rs_to_pre cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      total++;
      if ({rc, pdn, busy, fail} !== 5'b00_0_1_0) begin
         bad++; $display("FAIL restart_vs_timeout got=%b want=00010", {rc, pdn, busy, fail});
      end
      total++;
      if (dut_vec !== exp_vec()) begin
         bad++; $display("FAIL rs_to cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 63) == 0) PLL_LOCK = ~PLL_LOCK;
         RESTART = ($urandom_range(0, 299) == 0);
         tick();
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL random cyc=%0d got=%b want=%b", m_now, dut_vec, exp_vec());
         end
      end
      RESTART = 1'b0;
   endtask

   task automatic test_reset_midpwrup();
      PLL_LOCK = 1'b1;
      RESTART = 1'b1; tick(); RESTART = 1'b0;
      while (m_now - m_ph < 300) tick();
      total++;
      if ({pdn, pdn1, pdn8, busy, busy1, busy8} !== 6'b111111) begin
         bad++; $display("FAIL pwrup_state got=%b want=111111", {pdn, pdn1, pdn8, busy, busy1, busy8});
      end
      #2;
      RESET_N = 1'b0;
      #1;
      model_reset();
      total++;
      if (dut_vec !== exp_vec()) begin
         bad++; $display("FAIL async_reset_n4 got=%b want=%b", dut_vec, exp_vec());
      end
      total++;
      if ({pdn1, en1, busy1, done1, fail1, rc1} !== 7'b0010000) begin
         bad++; $display("FAIL async_reset_n1 got=%b want=0010000", {pdn1, en1, busy1, done1, fail1, rc1});
      end
      total++;
      if ({pdn8, en8, busy8, done8, fail8, rc8} !== {1'b0, 8'h00, 5'b10000}) begin
         bad++; $display("FAIL async_reset_n8 got=%b", {pdn8, en8, busy8, done8, fail8, rc8});
      end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_timeout();
      test_lock_loss();
      test_en_glitch();
      test_restart_timeout();
      test_random();
      test_reset_midpwrup();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_fb_resync_sequencer.md
Name: pll_fb_resync_sequencer

Overview:
- Parametrised successor to the single-shot PLL external/post-divider feedback resync logic.
- Sequences PLL powerdown, divider disable, powerup, lock wait and output enable for N outputs.
- Adds per-output staggered enables, lock-timeout with bounded retries, re-sequencing on lock loss, and a software restart.
- Sits between the CCC PLL hard macro and the fabric clock consumers.

Parameters:
- NUM_OUTPUTS, 4, number of output divider enables (1..8).
- CNT_W, 16, width of the cycle counter.
- DIS_WAIT, 200, FREF cycles to hold POWERDOWN_N low with dividers disabled.
- PD_WAIT, 200, FREF cycles after powerdown release before lock is sampled.
- LOCK_TIMEOUT, 4096, FREF cycles allowed in the lock wait before a retry.
- STAGGER, 8, FREF cycles between enabling successive outputs.
- MAX_RETRIES, 3, lock timeouts tolerated before FAIL. RETRY_CNT is 2 bits wide, so MAX_RETRIES ≤ 3.

Ports:
- FREF  in  1  reference clock. All flops update on the falling edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- PLL_LOCK  in  1  PLL lock, asynchronous to FREF. Passes through a 2-flop synchroniser (LOCK_S) before use.
- RESTART  in  1  synchronous single-cycle request to re-run the sequence.
- POWERDOWN_N  out  1  PLL powerdown, active-low.
- OUTx_EN  out  NUM_OUTPUTS  output divider enables.
- BUSY  out  1  high while a sequence is in progress.
- DONE  out  1  high in RUN.
- FAIL  out  1  high in FAILED, sticky.
- RETRY_CNT  out  2  number of lock timeouts in the current sequence.

Behaviour:
- Reset values: state=PD, cnt=0, POWERDOWN_N=0, OUTx_EN=0, BUSY=1, DONE=0, FAIL=0, RETRY_CNT=0, synchroniser flops=0.
- All outputs are registered.
- The counter is a saturating CNT_W-bit counter, cleared on every state entry.

States and transitions:
- PD: POWERDOWN_N=0, OUTx_EN=all 0. Exit to PWRUP when cnt==DIS_WAIT-1, so PD lasts exactly DIS_WAIT cycles.
- PWRUP: POWERDOWN_N=1. Exit to LOCKW when cnt==PD_WAIT-1. LOCK_S is ignored in this state.
- LOCKW, lock seen: if LOCK_S=1, go to EN with idx=0.
- LOCKW, timeout: if cnt==LOCK_TIMEOUT-1 and LOCK_S=0:
  - if RETRY_CNT<MAX_RETRIES, increment RETRY_CNT and go to PD;
  - otherwise go to FAILED.
  - If LOCK_S=1 on the timeout cycle, lock wins.
- EN:
  - OUTx_EN[idx] is set on the entry cycle. Then idx increments every STAGGER cycles, setting the next bit.
  - After bit NUM_OUTPUTS-1 is set and STAGGER cycles elapse, go to RUN.
  - With NUM_OUTPUTS=1, RUN is entered STAGGER cycles after EN entry.
  - If LOCK_S drops during EN, go to PD and leave RETRY_CNT unchanged.
- RUN:
  - DONE=1, BUSY=0. RETRY_CNT is held for observation.
  - LOCK_S=0 means lock was lost: go to PD next cycle and clear RETRY_CNT.
  - All OUTx_EN bits clear on the PD entry cycle.
- FAILED:
  - FAIL=1, BUSY=0, POWERDOWN_N=0, OUTx_EN=0.
  - Stays in FAILED until RESTART or reset.

RESTART:
- In any state, RESTART=1 forces PD next cycle and clears RETRY_CNT and FAIL.
- RESTART has priority over every other transition, including a lock timeout on the same cycle.
- RESTART while already in PD restarts the DIS_WAIT count.

Other rules:
- BUSY = state ∈ {PD, PWRUP, LOCKW, EN}.
- OUTx_EN never rises while POWERDOWN_N=0.
- OUTx_EN bits are only set in EN and cleared only on entry to PD or FAILED. No bit toggles otherwise.
- Reset asserted mid-sequence returns all outputs to their reset values immediately (asynchronous).
- Illegal state encodings go to PD.

Test Plan:
- Reset release with PLL_LOCK tied high, defaults:
  - POWERDOWN_N rises at cycle 200 and LOCKW is entered at cycle 400.
  - OUTx_EN goes 0001 at 401, 0011 at 409, 0111 at 417, 1111 at 425.
  - DONE=1 at cycle 433.
- PLL_LOCK tied low, LOCK_TIMEOUT=16:
  - RETRY_CNT steps 1, 2, 3 with PD re-entered each time.
  - On the 4th timeout FAIL=1 and POWERDOWN_N=0.
  - Then pulse RESTART: FAIL=0 and RETRY_CNT=0 next cycle.
- Lock loss in RUN:
  - Drop PLL_LOCK. 2 cycles later (synchroniser) the state moves to PD, with OUTx_EN=0 and POWERDOWN_N=0 on the same edge.
  - The full sequence then repeats and DONE returns.
- PLL_LOCK glitch low during EN after 2 outputs are enabled: OUTx_EN returns to 0000 and RETRY_CNT is unchanged.
- RESTART on the same cycle as a lock timeout: the state goes to PD and RETRY_CNT=0, not incremented.
- RESET_N asserted mid-PWRUP: all outputs go to reset values without waiting for an FREF edge. Repeat with NUM_OUTPUTS=1 and with NUM_OUTPUTS=8.
